// File: rtl/calc_frame_pkg.sv
// -----------------------------------------------------------------------------
// calc_frame_pkg
// Shared constants and types for the calculator command-frame controller.
//   SYNC_BYTE        : frame start marker (0xAA)
//   OPC_*_CH         : ASCII opcode characters '+', '-', '*', '/'
//   op_e             : 2-bit operation encoding presented on cmd_op
//   state_e          : frame sequencer states (ST_CKS only exists when
//                      FRAME_CKSUM_EN is defined)
// Helper functions decode an ASCII opcode byte into legality and op_e.
// -----------------------------------------------------------------------------
package calc_frame_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hAA;
    localparam logic [7:0] OPC_ADD_CH = 8'h2B;
    localparam logic [7:0] OPC_SUB_CH = 8'h2D;
    localparam logic [7:0] OPC_MUL_CH = 8'h2A;
    localparam logic [7:0] OPC_DIV_CH = 8'h2F;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPC  = 3'd1,
        ST_A_HI = 3'd2,
        ST_A_LO = 3'd3,
        ST_B_HI = 3'd4,
        ST_B_LO = 3'd5,
`ifdef FRAME_CKSUM_EN
        ST_CKS  = 3'd6,
`endif
        ST_HOLD = 3'd7
    } state_e;

    function automatic logic opc_is_legal(input logic [7:0] b);
        case (b)
            OPC_ADD_CH, OPC_SUB_CH, OPC_MUL_CH, OPC_DIV_CH: opc_is_legal = 1'b1;
            default:                                        opc_is_legal = 1'b0;
        endcase
    endfunction

    function automatic op_e opc_to_op(input logic [7:0] b);
        case (b)
            OPC_ADD_CH: opc_to_op = OP_ADD;
            OPC_SUB_CH: opc_to_op = OP_SUB;
            OPC_MUL_CH: opc_to_op = OP_MUL;
            OPC_DIV_CH: opc_to_op = OP_DIV;
            default:    opc_to_op = OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_frame_ctrl_timeout_timer.sv
// -----------------------------------------------------------------------------
// frame_timeout_timer
// Counts idle clocks between received bytes while a frame is in progress.
//   clk     in  : system clock
//   reset   in  : asynchronous active-high reset
//   clear   in  : a byte arrived this cycle; restart the count
//   enable  in  : a frame is being assembled; counting allowed
//   expire  out : the count has reached TIMEOUT_CYCLES-1 with no byte this
//                 cycle (combinational decode of the counter register)
// -----------------------------------------------------------------------------
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 104168,
    parameter int TMO_W          = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] count;

    // An arriving byte takes priority over expiry, so clear masks the decode.
    assign expire = enable && !clear && (count == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-clock counter; held at zero outside a frame and restarted on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {TMO_W{1'b0}};
        end else if (clear || !enable || expire) begin
            count <= {TMO_W{1'b0}};
        end else begin
            count <= count + TMO_W'(1);
        end
    end

endmodule

// File: rtl/calc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// calc_frame_ctrl
// Turns the UART receiver's byte stream into calculator command frames:
//   SYNC(0xAA) OPC A_HI A_LO B_HI B_LO [CKS]
// and offers one command at a time on a valid/ready handshake.
//
// Build option: FRAME_CKSUM_EN -- when defined, a trailing XOR checksum byte
// over OPC..B_LO is required; when undefined the frame ends at B_LO and
// err_cksum is tied low.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_data, rx_ready     received byte and its single-cycle strobe
//   cmd_valid, cmd_ready  command handshake
//   cmd_op, cmd_a, cmd_b  decoded operation and big-endian operands
//   busy                  high whenever the sequencer is not idle
//   err_opcode/cksum/timeout/overrun  one-cycle error pulses
//   err_cnt               saturating count of error pulses
// -----------------------------------------------------------------------------
module calc_frame_ctrl
    import calc_frame_pkg::*;
#(
    parameter int CLK_FREQ       = 25000000,
    // Four 10-bit byte times at 9600 baud, rounded up per byte.
    parameter int TIMEOUT_CYCLES = 4 * ((CLK_FREQ * 10 + 9599) / 9600),
    parameter int TMO_W          = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [15:0] cmd_a,
    output logic [15:0] cmd_b,
    output logic        busy,
    output logic        err_opcode,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [7:0]  err_cnt
);

    state_e state;
    logic   in_frame;
    logic   tmo_expire;
    logic   handshake;
    logic   det_opcode;
    logic   det_cksum;
    logic   det_overrun;
    logic   det_any;

`ifdef FRAME_CKSUM_EN
    logic [7:0] cks_acc;
`endif

    assign in_frame    = (state != ST_IDLE) && (state != ST_HOLD);
    assign handshake   = cmd_valid && cmd_ready;
    assign det_opcode  = rx_ready && (state == ST_OPC) && !opc_is_legal(rx_data);
    assign det_overrun = rx_ready && (state == ST_HOLD) && !handshake;
`ifdef FRAME_CKSUM_EN
    assign det_cksum   = rx_ready && (state == ST_CKS) && (rx_data != cks_acc);
`else
    assign det_cksum   = 1'b0;
    assign err_cksum   = 1'b0;
`endif
    // Timeout requires no byte this cycle, so at most one detector fires.
    assign det_any     = det_opcode | det_cksum | tmo_expire | det_overrun;

    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_ready),
        .enable (in_frame),
        .expire (tmo_expire)
    );

    // Frame sequencer with registered command, status and error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_op      <= 2'b00;
            cmd_a       <= 16'h0000;
            cmd_b       <= 16'h0000;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_cnt     <= 8'h00;
`ifdef FRAME_CKSUM_EN
            err_cksum   <= 1'b0;
            cks_acc     <= 8'h00;
`endif
        end else begin
            err_opcode  <= det_opcode;
            err_timeout <= tmo_expire;
            err_overrun <= det_overrun;
`ifdef FRAME_CKSUM_EN
            err_cksum   <= det_cksum;
`endif
            if (det_any && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (tmo_expire) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_ready && (rx_data == SYNC_BYTE)) begin
                            state <= ST_OPC;
                            busy  <= 1'b1;
`ifdef FRAME_CKSUM_EN
                            cks_acc <= 8'h00;
`endif
                        end
                    end
                    ST_OPC: begin
                        if (rx_ready) begin
                            if (opc_is_legal(rx_data)) begin
                                cmd_op <= opc_to_op(rx_data);
                                state  <= ST_A_HI;
`ifdef FRAME_CKSUM_EN
                                cks_acc <= cks_acc ^ rx_data;
`endif
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_A_HI, ST_A_LO: begin
                        if (rx_ready) begin
                            cmd_a <= {cmd_a[7:0], rx_data};
                            state <= (state == ST_A_HI) ? ST_A_LO : ST_B_HI;
`ifdef FRAME_CKSUM_EN
                            cks_acc <= cks_acc ^ rx_data;
`endif
                        end
                    end
                    ST_B_HI: begin
                        if (rx_ready) begin
                            cmd_b <= {cmd_b[7:0], rx_data};
                            state <= ST_B_LO;
`ifdef FRAME_CKSUM_EN
                            cks_acc <= cks_acc ^ rx_data;
`endif
                        end
                    end
                    ST_B_LO: begin
                        if (rx_ready) begin
                            cmd_b <= {cmd_b[7:0], rx_data};
`ifdef FRAME_CKSUM_EN
                            cks_acc <= cks_acc ^ rx_data;
                            state   <= ST_CKS;
`else
                            state     <= ST_HOLD;
                            cmd_valid <= 1'b1;
`endif
                        end
                    end
`ifdef FRAME_CKSUM_EN
                    ST_CKS: begin
                        if (rx_ready) begin
                            if (rx_data == cks_acc) begin
                                state     <= ST_HOLD;
                                cmd_valid <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
`endif
                    ST_HOLD: begin
                        // A byte arriving with the handshake is judged as if idle,
                        // so a SYNC here starts the next frame without a gap.
                        if (handshake) begin
                            cmd_valid <= 1'b0;
                            if (rx_ready && (rx_data == SYNC_BYTE)) begin
                                state <= ST_OPC;
`ifdef FRAME_CKSUM_EN
                                cks_acc <= 8'h00;
`endif
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_frame_ctrl
// Directed and randomized frames against a frame-level reference model:
// expected commands come from the frame's fields, checksum from a plain XOR
// of the payload bytes, and errors/err_cnt from the frame rules.
// -----------------------------------------------------------------------------
module tb_calc_frame_ctrl;

    localparam int T = 16;
    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_OPC  = 4'b1000;
    localparam logic [3:0] E_CKS  = 4'b0100;
    localparam logic [3:0] E_TMO  = 4'b0010;
    localparam logic [3:0] E_OVR  = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        busy;
    logic        err_opcode;
    logic        err_cksum;
    logic        err_timeout;
    logic        err_overrun;
    logic [7:0]  err_cnt;

    calc_frame_ctrl #(
        .CLK_FREQ       (25000000),
        .TIMEOUT_CYCLES (T),
        .TMO_W          (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          m_err_cnt = 0;
    logic [7:0]  op_chars [4];
    logic [7:0]  frame_q [$];
    logic [1:0]  exp_op;
    logic [15:0] exp_a;
    logic [15:0] exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic note_err();
        if (m_err_cnt < 255) m_err_cnt++;
    endtask

    function automatic logic is_op_char(input logic [7:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) if (op_chars[i] == b) r = 1'b1;
        return r;
    endfunction

    task automatic chk_errs(input string tag, input logic [3:0] errs);
        chk({tag, "/errs"}, {28'd0, err_opcode, err_cksum, err_timeout, err_overrun}, {28'd0, errs});
        chk({tag, "/err_cnt"}, {24'd0, err_cnt}, 32'(m_err_cnt));
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] errs);
        chk({tag, "/valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        chk({tag, "/op"}, 32'(cmd_op), 32'(exp_op));
        chk({tag, "/a"}, 32'(cmd_a), 32'(exp_a));
        chk({tag, "/b"}, 32'(cmd_b), 32'(exp_b));
        chk_errs(tag, errs);
    endtask

    // Build a frame from its fields; bad_cks corrupts the trailing checksum.
    task automatic build_frame(input int idx, input logic [15:0] a, input logic [15:0] b,
                               input logic bad_cks);
        logic [7:0] x;
        exp_op = 2'(idx);
        exp_a  = a;
        exp_b  = b;
        frame_q = {};
        frame_q.push_back(8'hAA);
        frame_q.push_back(op_chars[idx]);
        frame_q.push_back(a[15:8]);
        frame_q.push_back(a[7:0]);
        frame_q.push_back(b[15:8]);
        frame_q.push_back(b[7:0]);
        x = 8'h00;
        for (int i = 1; i < 6; i++) x = x ^ frame_q[i];
        if (bad_cks) x = x ^ 8'($urandom_range(1, 255));
`ifdef FRAME_CKSUM_EN
        frame_q.push_back(x);
`endif
    endtask

    task automatic send_frame(input string tag, input int start, input int gap_max);
        for (int i = start; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (i < frame_q.size() - 1) begin
                chk({tag, "/mid_busy"}, 32'(busy), 32'd1);
                chk({tag, "/mid_valid"}, 32'(cmd_valid), 32'd0);
                chk_errs({tag, "/mid"}, E_NONE);
                repeat ($urandom_range(0, gap_max)) tick();
            end
        end
    endtask

    task automatic accept(input string tag, input int delay);
        cmd_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            check_cmd({tag, "/stall"}, E_NONE);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, "/acc_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "/acc_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          k;
        int          kind;
        int          idx;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  junk;

        op_chars[0] = 8'h2B;
        op_chars[1] = 8'h2D;
        op_chars[2] = 8'h2A;
        op_chars[3] = 8'h2F;
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_ready  = 1'b0;
        cmd_ready = 1'b0;

        // Reset state
        tick();
        chk("reset/ctl", {16'd0, cmd_valid, busy, err_opcode, err_cksum, err_timeout,
                          err_overrun, cmd_op, err_cnt}, 32'd0);
        chk("reset/data", {cmd_a, cmd_b}, 32'd0);
        reset = 1'b0;
        tick();

        // Good frame with cmd_ready held high
        cmd_ready = 1'b1;
        build_frame(0, 16'h000C, 16'h0022, 1'b0);
        send_frame("good", 0, 0);
        check_cmd("good", E_NONE);
        tick();
        chk("good/hs_valid", 32'(cmd_valid), 32'd0);
        chk("good/hs_busy", 32'(busy), 32'd0);
        cmd_ready = 1'b0;

        // Illegal opcode, then a normal frame
        send_byte(8'hAA);
        send_byte(8'h41);
        note_err();
        chk_errs("badop", E_OPC);
        chk("badop/busy", 32'(busy), 32'd0);
        tick();
        chk_errs("badop/after", E_NONE);
        build_frame(3, 16'h1234, 16'h0007, 1'b0);
        send_frame("badop_next", 0, 1);
        check_cmd("badop_next", E_NONE);
        accept("badop_next", 1);

`ifdef FRAME_CKSUM_EN
        // Checksum mismatch
        frame_q = {8'hAA, 8'h2D, 8'h12, 8'h34, 8'h00, 8'h01, 8'h06};
        send_frame("badcks", 0, 0);
        note_err();
        chk_errs("badcks", E_CKS);
        chk("badcks/valid", 32'(cmd_valid), 32'd0);
        chk("badcks/busy", 32'(busy), 32'd0);
        tick();
        chk_errs("badcks/after", E_NONE);
`endif

        // Inter-byte timeout: pulse appears T edges after the last byte's edge
        send_byte(8'hAA);
        send_byte(8'h2A);
        for (k = 1; k <= T + 4; k++) begin
            tick();
            if (err_timeout === 1'b1) break;
        end
        chk("tmo/delay", 32'(k), 32'(T));
        note_err();
        chk_errs("tmo", E_TMO);
        chk("tmo/busy", 32'(busy), 32'd0);

        // Byte landing on the expiry cycle wins over the timeout
        build_frame(2, 16'h0102, 16'h0304, 1'b0);
        send_byte(frame_q[0]);
        send_byte(frame_q[1]);
        for (int i = 0; i < T - 1; i++) begin
            tick();
            chk("tmo_edge/quiet", 32'(err_timeout), 32'd0);
        end
        send_frame("tmo_edge", 2, 0);
        check_cmd("tmo_edge", E_NONE);
        accept("tmo_edge", 0);

        // Backpressure: overrun keeps the command, then handshake + SYNC
        build_frame(1, 16'hBEEF, 16'h00AA, 1'b0);
        send_frame("bp", 0, 2);
        check_cmd("bp", E_NONE);
        tick();
        check_cmd("bp/hold", E_NONE);
        send_byte(8'hAA);
        note_err();
        check_cmd("bp/ovr", E_OVR);
        tick();
        check_cmd("bp/ovr_after", E_NONE);
        cmd_ready = 1'b1;
        send_byte(8'hAA);
        cmd_ready = 1'b0;
        chk("bp/hs_valid", 32'(cmd_valid), 32'd0);
        chk("bp/hs_busy", 32'(busy), 32'd1);
        build_frame(3, 16'h8001, 16'h7FFE, 1'b0);
        send_frame("bp_next", 1, 1);
        check_cmd("bp_next", E_NONE);
        accept("bp_next", 0);

        // Reset mid-frame
        build_frame(0, 16'h0055, 16'h0066, 1'b0);
        send_byte(8'hAA);
        send_byte(8'h2B);
        send_byte(8'h00);
        reset = 1'b1;
        #1;
        m_err_cnt = 0;
        chk("rst_mid/ctl", {16'd0, cmd_valid, busy, err_opcode, err_cksum, err_timeout,
                            err_overrun, cmd_op, err_cnt}, 32'd0);
        chk("rst_mid/data", {cmd_a, cmd_b}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rst_mid/busy", 32'(busy), 32'd0);
        chk_errs("rst_mid", E_NONE);
        send_frame("rst_next", 0, 0);
        check_cmd("rst_next", E_NONE);
        accept("rst_next", 2);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 3));
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hAA) junk = 8'h55;
                send_byte(junk);
                chk("rnd/junk_busy", 32'(busy), 32'd0);
                chk_errs("rnd/junk", E_NONE);
            end
            if (kind == 0) begin
                junk = 8'($urandom);
                while (is_op_char(junk)) junk = 8'($urandom);
                send_byte(8'hAA);
                send_byte(junk);
                note_err();
                chk_errs("rnd/badop", E_OPC);
                chk("rnd/badop_busy", 32'(busy), 32'd0);
                tick();
            end
`ifdef FRAME_CKSUM_EN
            else if (kind == 1) begin
                build_frame(idx, ra, rb, 1'b1);
                send_frame("rnd/badcks", 0, T - 2);
                note_err();
                chk_errs("rnd/badcks", E_CKS);
                chk("rnd/badcks_valid", 32'(cmd_valid), 32'd0);
                tick();
            end
`endif
            else begin
                build_frame(idx, ra, rb, 1'b0);
                send_frame("rnd/good", 0, T - 2);
                check_cmd("rnd/good", E_NONE);
                accept("rnd/good", int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
